// File: rtl/core_run_sequencer.sv
// Sequences test runs across a set of cores: waits for the program image, pulses tile
// resets, releases core resets one at a time or all together, and latches pass/fail/timeout.
module core_run_sequencer #(
  parameter  int NUM_CORES       = 4,
  parameter  int TIMEOUT_W       = 24,
  parameter  int RST_HOLD_CYCLES = 2,
  localparam int CW              = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic                 mode,
  input  logic                 per_core_reset,
  input  logic                 program_loaded,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic [NUM_CORES-1:0] core_pass,
  input  logic [NUM_CORES-1:0] core_fail,
  output logic [NUM_CORES-1:0] tile_reset,
  output logic [NUM_CORES-1:0] core_reset,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CORES-1:0] pass_vec,
  output logic [NUM_CORES-1:0] fail_vec,
  output logic [NUM_CORES-1:0] timeout_vec,
  output logic [CW-1:0]        cur_core
);

  typedef enum logic [2:0] {IDLE, WAIT_LOAD, TILE_RST, RELEASE, RUN, NEXT, DONE} state_e;

  localparam logic [TIMEOUT_W-1:0] HOLD = TIMEOUT_W'(RST_HOLD_CYCLES);

  state_e                 state_q, state_d;
  logic [NUM_CORES-1:0]   mask_q, mask_d;
  logic                   mode_q, mode_d;
  logic                   pcr_q, pcr_d;
  logic [TIMEOUT_W-1:0]   limit_q, limit_d;
  logic [TIMEOUT_W-1:0]   timer_q, timer_d;
  logic [NUM_CORES-1:0]   tile_reset_q, tile_reset_d;
  logic [NUM_CORES-1:0]   core_reset_q, core_reset_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CW-1:0]          cur_core_q, cur_core_d;
  logic [NUM_CORES-1:0]   pass_q, pass_d;
  logic [NUM_CORES-1:0]   fail_q, fail_d;
  logic [NUM_CORES-1:0]   tmo_q, tmo_d;
  logic [NUM_CORES-1:0]   resolved_q, resolved_d;

  logic [CW-1:0]          first_idx, next_idx;
  logic                   next_found;
  logic                   tmo_hit;
  logic [TIMEOUT_W-1:0]   timer_inc;

  // Descending scan so the lowest qualifying index is the one that sticks.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (core_mask[i]) first_idx = CW'(i);
      if (mask_q[i] && (i > int'(cur_core_q))) begin
        next_idx   = CW'(i);
        next_found = 1'b1;
      end
    end
  end

  assign tmo_hit   = (limit_q != '0) && (timer_q == limit_q);
  assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    mode_d       = mode_q;
    pcr_d        = pcr_q;
    limit_d      = limit_q;
    timer_d      = timer_q;
    tile_reset_d = tile_reset_q;
    core_reset_d = core_reset_q;
    cur_core_d   = cur_core_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    tmo_d        = tmo_q;
    resolved_d   = resolved_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d     = core_mask;
          mode_d     = mode;
          pcr_d      = per_core_reset;
          limit_d    = timeout_limit;
          timer_d    = '0;
          pass_d     = '0;
          fail_d     = '0;
          tmo_d      = '0;
          resolved_d = '0;
          cur_core_d = mode ? '0 : first_idx;
          state_d    = (core_mask == '0) ? DONE : WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        if (program_loaded) begin
          tile_reset_d = '0;
          state_d      = RELEASE;
        end
      end
      TILE_RST: begin
        if (timer_q >= HOLD) begin
          tile_reset_d = '0;
          state_d      = RELEASE;
        end else begin
          timer_d = timer_inc;
        end
      end
      RELEASE: begin
        timer_d = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        state_d = RUN;
        if (mode_q) core_reset_d = core_reset_q & ~mask_q;
        else        core_reset_d[cur_core_q] = 1'b0;
      end
      RUN: begin
        timer_d = timer_inc;
        if (!mode_q) begin
          if (core_fail[cur_core_q] || core_pass[cur_core_q] || tmo_hit) begin
            // Fail beats pass, and any status beats a coincident timeout.
            if (core_fail[cur_core_q])      fail_d[cur_core_q] = 1'b1;
            else if (core_pass[cur_core_q]) pass_d[cur_core_q] = 1'b1;
            else                            tmo_d[cur_core_q]  = 1'b1;
            core_reset_d[cur_core_q] = 1'b1;
            state_d = NEXT;
          end
        end else begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (mask_q[i] && !resolved_q[i] && (core_fail[i] || core_pass[i] || tmo_hit)) begin
              if (core_fail[i])      fail_d[i] = 1'b1;
              else if (core_pass[i]) pass_d[i] = 1'b1;
              else                   tmo_d[i]  = 1'b1;
              resolved_d[i]   = 1'b1;
              core_reset_d[i] = 1'b1;
            end
          end
          if ((resolved_d & mask_q) == mask_q) state_d = NEXT;
        end
      end
      NEXT: begin
        if (!mode_q && next_found) begin
          cur_core_d = next_idx;
          if (pcr_q) begin
            tile_reset_d = '1;
            timer_d      = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
            state_d      = TILE_RST;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      mode_q       <= 1'b0;
      pcr_q        <= 1'b0;
      limit_q      <= '0;
      timer_q      <= '0;
      tile_reset_q <= '1;
      core_reset_q <= '1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cur_core_q   <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      tmo_q        <= '0;
      resolved_q   <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      pcr_q        <= pcr_d;
      limit_q      <= limit_d;
      timer_q      <= timer_d;
      tile_reset_q <= tile_reset_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cur_core_q   <= cur_core_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      tmo_q        <= tmo_d;
      resolved_q   <= resolved_d;
    end
  end

  assign tile_reset  = tile_reset_q;
  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cur_core    = cur_core_q;
  assign pass_vec    = pass_q;
  assign fail_vec    = fail_q;
  assign timeout_vec = tmo_q;

endmodule
